// File: rtl/and_gate_sweep_ctrl.sv
// Self-test sequencer for a 2-input AND gate: walks all four input vectors,
// lets each settle, samples y against a&b and records mismatches.
module and_gate_sweep_ctrl #(
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter int unsigned ERR_W         = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             y,
  output logic             a,
  output logic             b,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic [1:0]       fail_vec,
  output logic             fail_valid,
  output logic [1:0]       vec_idx
);

  localparam int unsigned CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [ERR_W-1:0] ERR_MAX = '1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_APPLY,
    S_WAIT,
    S_SAMPLE,
    S_DONE
  } state_e;

  state_e           state_q, state_d;
  logic [1:0]       vec_idx_q, vec_idx_d;
  logic [CNT_W-1:0] settle_cnt_q, settle_cnt_d;
  logic [ERR_W-1:0] err_count_q, err_count_d;
  logic [1:0]       fail_vec_q, fail_vec_d;
  logic             fail_valid_q, fail_valid_d;
  logic             pass_q, pass_d;

  logic             expected_c;
  logic             mismatch_c;
  logic [ERR_W-1:0] err_inc_c;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      vec_idx_q    <= 2'b00;
      settle_cnt_q <= '0;
      err_count_q  <= '0;
      fail_vec_q   <= 2'b00;
      fail_valid_q <= 1'b0;
      pass_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      vec_idx_q    <= vec_idx_d;
      settle_cnt_q <= settle_cnt_d;
      err_count_q  <= err_count_d;
      fail_vec_q   <= fail_vec_d;
      fail_valid_q <= fail_valid_d;
      pass_q       <= pass_d;
    end
  end

  // Sample-time comparison and saturating error increment
  always_comb begin
    expected_c = vec_idx_q[1] & vec_idx_q[0];
    mismatch_c = (y != expected_c);
    err_inc_c  = (err_count_q == ERR_MAX) ? ERR_MAX : err_count_q + ERR_W'(1);
  end

  always_comb begin
    state_d      = state_q;
    vec_idx_d    = vec_idx_q;
    settle_cnt_d = settle_cnt_q;
    err_count_d  = err_count_q;
    fail_vec_d   = fail_vec_q;
    fail_valid_d = fail_valid_q;
    pass_d       = pass_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          err_count_d  = '0;
          fail_valid_d = 1'b0;
          fail_vec_d   = 2'b00;
          pass_d       = 1'b0;
          vec_idx_d    = 2'b00;
          state_d      = S_APPLY;
        end
      end
      S_APPLY: begin
        settle_cnt_d = CNT_W'(SETTLE_CYCLES - 1);
        state_d      = S_WAIT;
      end
      S_WAIT: begin
        if (settle_cnt_q == '0) begin
          state_d = S_SAMPLE;
        end else begin
          settle_cnt_d = settle_cnt_q - CNT_W'(1);
        end
      end
      S_SAMPLE: begin
        if (mismatch_c) begin
          err_count_d = err_inc_c;
          if (!fail_valid_q) begin
            fail_vec_d   = vec_idx_q;
            fail_valid_d = 1'b1;
          end
        end
        if (vec_idx_q == 2'b11) begin
          pass_d  = (err_count_d == '0);
          state_d = S_DONE;
        end else begin
          vec_idx_d = vec_idx_q + 2'b01;
          state_d   = S_APPLY;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Handshake and gate drive are pure decodes of registered state
  always_comb begin
    busy = (state_q == S_APPLY) || (state_q == S_WAIT) || (state_q == S_SAMPLE);
    done = (state_q == S_DONE);
    a    = busy & vec_idx_q[1];
    b    = busy & vec_idx_q[0];
  end

  assign pass       = pass_q;
  assign err_count  = err_count_q;
  assign fail_vec   = fail_vec_q;
  assign fail_valid = fail_valid_q;
  assign vec_idx    = vec_idx_q;

endmodule
